// File: rtl/jzjpcc_pkg.sv
// Shared types for the next-PC controller: opcodes, branch funct3 codes, controller states.
package jzjpcc_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned OPF3_W = 13;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_PRIV = 3'b000;

    typedef enum logic [4:0] {
        LOAD     = 5'b00000,
        MISC_MEM = 5'b00011,
        OP_IMM   = 5'b00100,
        AUIPC    = 5'b00101,
        STORE    = 5'b01000,
        OP       = 5'b01100,
        LUI      = 5'b01101,
        BRANCH   = 5'b11000,
        JALR     = 5'b11001,
        JAL      = 5'b11011,
        SYSTEM   = 5'b11100
    } opcode_t;

    typedef enum logic [1:0] {
        RUN,
        PENDING,
        HALT
    } pc_state_t;

    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/jzjpcc_branch_comparator.sv
// Combinational branch condition evaluator: funct3 selects the compare, result is taken_c.
module jzjpcc_branch_comparator
    import jzjpcc_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            taken_c
);

    always_comb begin
        taken_c = 1'b0;
        case (funct3)
            F3_BEQ:  taken_c = (rs1_data == rs2_data);
            F3_BNE:  taken_c = (rs1_data != rs2_data);
            F3_BLT:  taken_c = ($signed(rs1_data) <  $signed(rs2_data));
            F3_BGE:  taken_c = ($signed(rs1_data) >= $signed(rs2_data));
            F3_BLTU: taken_c = (rs1_data <  rs2_data);
            F3_BGEU: taken_c = (rs1_data >= rs2_data);
            default: taken_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/jzjpcc_next_pc_controller.sv
// Fetch PC owner: resolves BRANCH/JAL/JALR in decode, redirects fetch, squashes the wrong path.
// Optional JZJPCC_MISALIGN_TRAP_EN: misaligned taken targets halt with a sticky fault.
module jzjpcc_next_pc_controller
    import jzjpcc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [OPF3_W-1:0] opcode_funct3,
    input  logic              valid_decode,
    input  logic              stall_decode,
    input  logic [XLEN-1:0]   pc_decode,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [XLEN-1:0]   immediateI,
    input  logic [XLEN-1:0]   immediateB,
    input  logic [XLEN-1:0]   immediateJ,
    input  logic              fetch_ready,
    output logic [XLEN-1:0]   fetch_addr,
    output logic              fetch_valid,
    output logic              flush_decode,
    output logic              halted,
    output logic              fault
);

    opcode_t         opcode;
    logic [2:0]      funct3;
    logic            branch_taken_c;
    logic            taken;
    logic            resolve;
    logic            is_halt_op;
    logic            trap;
    logic            unused_ok;
    logic [XLEN-1:0] target_raw;
    logic [XLEN-1:0] target;
    pc_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] redirect_q, redirect_d;

    assign opcode = opcode_t'(opcode_funct3[4:0]);
    assign funct3 = opcode_funct3[12:10];

    jzjpcc_branch_comparator u_branch_comparator (
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .taken_c  (branch_taken_c)
    );

    // Control-flow decode: whether the decode instruction redirects, and where to
    always_comb begin
        taken      = 1'b0;
        target_raw = pc_decode + immediateB;
        case (opcode)
            BRANCH: begin
                taken      = branch_taken_c;
                target_raw = pc_decode + immediateB;
            end
            JAL: begin
                taken      = 1'b1;
                target_raw = pc_decode + immediateJ;
            end
            JALR: begin
                taken      = 1'b1;
                target_raw = (rs1_data + immediateI) & ~XLEN'(1);
            end
            default: begin
                taken      = 1'b0;
                target_raw = pc_decode + immediateB;
            end
        endcase
    end

    assign resolve    = valid_decode & ~stall_decode & (state_q == RUN);
    assign is_halt_op = (opcode == SYSTEM) && (funct3 == F3_PRIV);

`ifdef JZJPCC_MISALIGN_TRAP_EN
    logic fault_q;

    assign target    = target_raw;
    assign trap      = resolve & taken & target[1];
    assign fault     = fault_q;
    assign unused_ok = ^opcode_funct3[9:5];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_q | trap;
        end
    end
`else
    // Without the trap, low target bits are simply dropped
    assign target    = {target_raw[XLEN-1:2], 2'b00};
    assign trap      = 1'b0;
    assign fault     = 1'b0;
    assign unused_ok = ^{opcode_funct3[9:5], target_raw[1:0]};
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redirect_d   = redirect_q;
        fetch_addr   = pc_q;
        flush_decode = 1'b0;
        case (state_q)
            RUN: begin
                if (resolve && (is_halt_op || trap)) begin
                    state_d      = HALT;
                    flush_decode = 1'b1;
                end else if (resolve && taken) begin
                    flush_decode = 1'b1;
                    // Accepted redirect bypasses pc_q so only one slot is lost
                    if (fetch_ready) begin
                        fetch_addr = target;
                        pc_d       = pc_plus4(target);
                    end else begin
                        redirect_d = target;
                        state_d    = PENDING;
                    end
                end else if (fetch_ready) begin
                    pc_d = pc_plus4(pc_q);
                end
            end
            PENDING: begin
                flush_decode = 1'b1;
                fetch_addr   = redirect_q;
                if (fetch_ready) begin
                    pc_d    = pc_plus4(redirect_q);
                    state_d = RUN;
                end
            end
            HALT: begin
                flush_decode = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            redirect_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
        end
    end

    assign fetch_valid = (state_q != HALT);
    assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_jzjpcc_next_pc_controller.sv
// Scoreboard bench for jzjpcc_next_pc_controller: driver pushes model expectations, monitor compares.
module tb_jzjpcc_next_pc_controller;

    localparam logic [31:0] RST_PC     = 32'h0000_0100;
    localparam logic [4:0]  OPC_BRANCH = 5'b11000;
    localparam logic [4:0]  OPC_JALR   = 5'b11001;
    localparam logic [4:0]  OPC_JAL    = 5'b11011;
    localparam logic [4:0]  OPC_SYSTEM = 5'b11100;
    localparam logic [4:0]  OPC_OP     = 5'b01100;
    localparam logic [4:0]  OPC_LOAD   = 5'b00000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [12:0] opcode_funct3 = '0;
    logic        valid_decode = 1'b0;
    logic        stall_decode = 1'b0;
    logic        fetch_ready = 1'b0;
    logic [31:0] pc_decode = '0, rs1_data = '0, rs2_data = '0;
    logic [31:0] immediateI = '0, immediateB = '0, immediateJ = '0;
    logic [31:0] fetch_addr;
    logic        fetch_valid, flush_decode, halted, fault;

    always #5 clock = ~clock;

    jzjpcc_next_pc_controller #(.RESET_PC(RST_PC)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .opcode_funct3 (opcode_funct3),
        .valid_decode  (valid_decode),
        .stall_decode  (stall_decode),
        .pc_decode     (pc_decode),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .immediateI    (immediateI),
        .immediateB    (immediateB),
        .immediateJ    (immediateJ),
        .fetch_ready   (fetch_ready),
        .fetch_addr    (fetch_addr),
        .fetch_valid   (fetch_valid),
        .flush_decode  (flush_decode),
        .halted        (halted),
        .fault         (fault)
    );

    typedef struct {
        logic [31:0] addr;
        bit          fv;
        bit          fl;
        bit          h;
        bit          f;
    } exp_t;

    typedef struct {
        logic [4:0]  op;
        logic [2:0]  f3;
        bit          v, st, rdy, rst;
        logic [31:0] pcd, r1, r2, ii, ib, ij;
    } stim_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    // Reference state: architectural fetch pointer, outstanding redirect, halt/fault flags
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_redir = '0;
    bit          m_pend = 1'b0, m_halt = 1'b0, m_fault = 1'b0;

    function automatic bit ref_taken(input logic [4:0] op, input logic [2:0] f3,
                                     input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        if (op == OPC_JAL || op == OPC_JALR) return 1'b1;
        if (op != OPC_BRANCH) return 1'b0;
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return ua < ub;
            3'd7: return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_target(input stim_t s);
        logic [31:0] t;
        if (s.op == OPC_JALR) begin
            t = s.r1 + s.ii;
            if (t % 2 == 1) t = t - 32'd1;
        end else if (s.op == OPC_JAL) begin
            t = s.pcd + s.ij;
        end else begin
            t = s.pcd + s.ib;
        end
        return t;
    endfunction

    function automatic stim_t mk(input logic [4:0] op, input logic [2:0] f3, input bit v, input bit st,
                                 input logic [31:0] pcd, input logic [31:0] r1, input logic [31:0] r2,
                                 input logic [31:0] ii, input logic [31:0] ib, input logic [31:0] ij,
                                 input bit rdy);
        stim_t s;
        s.op = op; s.f3 = f3; s.v = v; s.st = st; s.rdy = rdy; s.rst = 1'b0;
        s.pcd = pcd; s.r1 = r1; s.r2 = r2; s.ii = ii; s.ib = ib; s.ij = ij;
        return s;
    endfunction

    function automatic stim_t idle(input bit rdy);
        return mk(OPC_OP, 3'd0, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0, rdy);
    endfunction

    function automatic stim_t rst_s();
        stim_t s;
        s = idle(1'b0);
        s.rst = 1'b1;
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t        e;
        bit          tk, res;
        logic [31:0] tgt;
        @(posedge clock);
        #1;
        reset_n       = !s.rst;
        opcode_funct3 = {s.f3, 5'($urandom), s.op};
        valid_decode  = s.v && !s.rst;
        stall_decode  = s.st;
        fetch_ready   = s.rdy;
        pc_decode     = s.pcd;
        rs1_data      = s.r1;
        rs2_data      = s.r2;
        immediateI    = s.ii;
        immediateB    = s.ib;
        immediateJ    = s.ij;
        if (s.rst) begin
            m_pc = RST_PC; m_redir = '0; m_pend = 1'b0; m_halt = 1'b0; m_fault = 1'b0;
        end
        e.fv   = !m_halt;
        e.h    = m_halt;
        e.f    = m_fault;
        e.fl   = m_halt || m_pend;
        e.addr = m_pend ? m_redir : m_pc;
        tk  = ref_taken(s.op, s.f3, s.r1, s.r2);
        tgt = ref_target(s);
`ifndef JZJPCC_MISALIGN_TRAP_EN
        tgt = tgt & 32'hFFFF_FFFC;
`endif
        res = s.v && !s.st && !s.rst;
        if (!s.rst) begin
            if (m_pend) begin
                if (s.rdy) begin
                    m_pc   = m_redir + 32'd4;
                    m_pend = 1'b0;
                end
            end else if (!m_halt) begin
                if (res && s.op == OPC_SYSTEM && s.f3 == 3'd0) begin
                    e.fl = 1'b1; m_halt = 1'b1;
`ifdef JZJPCC_MISALIGN_TRAP_EN
                end else if (res && tk && tgt[1]) begin
                    e.fl = 1'b1; m_halt = 1'b1; m_fault = 1'b1;
`endif
                end else if (res && tk) begin
                    e.fl = 1'b1;
                    if (s.rdy) begin
                        e.addr = tgt;
                        m_pc   = tgt + 32'd4;
                    end else begin
                        m_pend  = 1'b1;
                        m_redir = tgt;
                    end
                end else if (s.rdy) begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("fetch_addr",   fetch_addr,          e.addr);
                check("fetch_valid",  32'(fetch_valid),    32'(e.fv));
                check("flush_decode", 32'(flush_decode),   32'(e.fl));
                check("halted",       32'(halted),         32'(e.h));
                check("fault",        32'(fault),          32'(e.f));
            end
        end
    end

    initial begin
        stim_t s;
        int    wait_cycles;
        step(rst_s());
        step(rst_s());
        repeat (3) step(idle(1'b1));

        step(mk(OPC_BRANCH, 3'd0, 1, 0, 32'h200, 32'd5, 32'd5, '0, 32'hFFFF_FFF0, '0, 1));
        step(idle(1'b1));
        step(idle(1'b1));

        step(mk(OPC_JAL, 3'd0, 1, 0, 32'h40, '0, '0, '0, '0, 32'h800, 0));
        step(idle(1'b0));
        step(mk(OPC_BRANCH, 3'd0, 1, 0, 32'h500, 32'd1, 32'd1, '0, 32'h40, '0, 0));
        step(idle(1'b1));
        step(idle(1'b1));

        step(mk(OPC_JALR, 3'd0, 1, 1, '0, 32'h1001, '0, 32'd2, '0, '0, 1));
        step(mk(OPC_JALR, 3'd0, 1, 0, '0, 32'h1001, '0, 32'd2, '0, '0, 1));
        step(idle(1'b1));
        step(rst_s());
        step(idle(1'b1));

        step(mk(OPC_BRANCH, 3'd4, 1, 0, 32'h300, 32'hFFFF_FFFF, 32'd1, '0, 32'h20, '0, 1));
        step(idle(1'b1));
        step(mk(OPC_BRANCH, 3'd6, 1, 0, 32'h300, 32'hFFFF_FFFF, 32'd1, '0, 32'h20, '0, 1));
        step(idle(1'b1));

        step(mk(OPC_JAL, 3'd0, 1, 0, '0, '0, '0, '0, '0, 32'hFFFF_FFF8, 1));
        step(idle(1'b1));
        step(idle(1'b1));

        step(mk(OPC_JAL, 3'd0, 1, 0, 32'h80, '0, '0, '0, '0, 32'h100, 0));
        step(idle(1'b0));
        step(rst_s());
        step(idle(1'b1));

        step(mk(OPC_SYSTEM, 3'd0, 1, 0, '0, '0, '0, '0, '0, '0, 1));
        step(idle(1'b1));
        step(idle(1'b1));
        step(rst_s());
        step(idle(1'b1));
        step(idle(1'b1));

        for (int i = 0; i < 2000; i++) begin
            if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
                s = rst_s();
            end else begin
                s = idle(1'b0);
                case ($urandom_range(0, 6))
                    0, 1:    s.op = OPC_BRANCH;
                    2:       s.op = OPC_JAL;
                    3:       s.op = OPC_JALR;
                    4:       s.op = OPC_OP;
                    5:       s.op = OPC_LOAD;
                    default: s.op = OPC_SYSTEM;
                endcase
                s.f3 = 3'($urandom_range(0, 7));
                if (s.op == OPC_SYSTEM) s.f3 = ($urandom_range(0, 7) == 0) ? 3'd0 : 3'd1;
                s.v   = ($urandom_range(0, 3) != 0);
                s.st  = ($urandom_range(0, 3) == 0);
                s.rdy = ($urandom_range(0, 3) != 0);
                s.pcd = $urandom & 32'hFFFF_FFFC;
                s.r1  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 7)) - 32'd4;
                s.r2  = ($urandom_range(0, 2) == 0) ? s.r1 : 32'($urandom_range(0, 7)) - 32'd4;
                s.ii  = $urandom;
                s.ib  = $urandom & 32'hFFFF_FFFE;
                s.ij  = $urandom & 32'hFFFF_FFFE;
            end
            step(s);
        end

        wait_cycles = 0;
        while (exp_q.size() != 0 && wait_cycles < 10) begin
            @(posedge clock);
            wait_cycles++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
